// File: rtl/pipeline_hazard_sequencer.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use stalls, branch flushes,
// multi-cycle mult/div occupancy of EX, and saturating stall/flush counters.
module pipeline_hazard_sequencer #(
  parameter int MULDIV_LATENCY = 4,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ID_EX_MemRead,
  input  logic [4:0]           ID_EX_RegisterRt,
  input  logic [4:0]           IF_ID_RegisterRs,
  input  logic [4:0]           IF_ID_RegisterRt,
  input  logic                 in_BranchControl,
  input  logic                 IF_ID_MulDiv,
  input  logic                 clear_counters,
  output logic                 PCWrite,
  output logic                 IF_ID_Write,
  output logic                 ID_EX_Write,
  output logic                 ID_EX_Bubble,
  output logic                 EX_MEM_Bubble,
  output logic                 IF_ID_Flush,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] stall_count,
  output logic [CNT_WIDTH-1:0] flush_count
);

  localparam logic [0:0] RUN    = 1'b0;
  localparam logic [0:0] MULDIV = 1'b1;
  localparam logic [3:0] REMAIN_INIT = 4'(MULDIV_LATENCY - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  logic [0:0]           r_state;
  logic [3:0]           r_remain;
  logic [CNT_WIDTH-1:0] r_stall_count;
  logic [CNT_WIDTH-1:0] r_flush_count;

  logic w_flush;
  logic w_load_use;
  logic w_accept_muldiv;

  assign w_flush    = in_BranchControl;
  assign w_load_use = ID_EX_MemRead && (ID_EX_RegisterRt != 5'd0) &&
                      ((ID_EX_RegisterRt == IF_ID_RegisterRs) ||
                       (ID_EX_RegisterRt == IF_ID_RegisterRt));
  assign w_accept_muldiv = (r_state == RUN) && IF_ID_MulDiv && !w_flush &&
                           !w_load_use && (MULDIV_LATENCY > 1);

  // Controls are forced low while reset is held, independent of the clock.
  always_comb begin
    PCWrite       = 1'b0;
    IF_ID_Write   = 1'b0;
    ID_EX_Write   = 1'b0;
    ID_EX_Bubble  = 1'b0;
    EX_MEM_Bubble = 1'b0;
    IF_ID_Flush   = 1'b0;
    busy          = 1'b0;
    if (!reset) begin
      if (r_state == MULDIV) begin
        EX_MEM_Bubble = 1'b1;
        busy          = 1'b1;
      end else if (w_flush) begin
        PCWrite      = 1'b1;
        IF_ID_Write  = 1'b1;
        ID_EX_Write  = 1'b1;
        ID_EX_Bubble = 1'b1;
        IF_ID_Flush  = 1'b1;
      end else if (w_load_use) begin
        ID_EX_Write  = 1'b1;
        ID_EX_Bubble = 1'b1;
      end else begin
        PCWrite     = 1'b1;
        IF_ID_Write = 1'b1;
        ID_EX_Write = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= RUN;
      r_remain <= 4'd0;
    end else begin
      case (r_state)
        RUN: begin
          if (w_accept_muldiv) begin
            r_state  <= MULDIV;
            r_remain <= REMAIN_INIT;
          end
        end
        default: begin
          r_remain <= r_remain - 4'd1;
          if (r_remain == 4'd1) r_state <= RUN;
        end
      endcase
    end
  end

  // Counters saturate; a clear request overrides the increment of the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stall_count <= '0;
      r_flush_count <= '0;
    end else if (clear_counters) begin
      r_stall_count <= '0;
      r_flush_count <= '0;
    end else begin
      if (!PCWrite && (r_stall_count != CNT_MAX)) r_stall_count <= r_stall_count + 1'b1;
      if (IF_ID_Flush && (r_flush_count != CNT_MAX)) r_flush_count <= r_flush_count + 1'b1;
    end
  end

  assign stall_count = r_stall_count;
  assign flush_count = r_flush_count;

endmodule

// File: tb/tb_pipeline_hazard_sequencer.sv
// Directed bench for pipeline_hazard_sequencer: RUN-state vector table plus
// hand-written mult/div, reset and saturation sequences.
module tb_pipeline_hazard_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       mr;
  logic [4:0] exrt, rs, rt;
  logic       br, md, clr;

  logic       pcw0, ifw0, idw0, idb0, exb0, fl0, busy0;
  logic [3:0] st0, fc0;
  logic       pcw1, ifw1, idw1, idb1, exb1, fl1, busy1;
  logic [3:0] st1, fc1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipeline_hazard_sequencer #(.MULDIV_LATENCY(4), .CNT_WIDTH(4)) dut0 (
    .clk(clk), .reset(reset), .ID_EX_MemRead(mr), .ID_EX_RegisterRt(exrt),
    .IF_ID_RegisterRs(rs), .IF_ID_RegisterRt(rt), .in_BranchControl(br),
    .IF_ID_MulDiv(md), .clear_counters(clr), .PCWrite(pcw0), .IF_ID_Write(ifw0),
    .ID_EX_Write(idw0), .ID_EX_Bubble(idb0), .EX_MEM_Bubble(exb0),
    .IF_ID_Flush(fl0), .busy(busy0), .stall_count(st0), .flush_count(fc0));

  pipeline_hazard_sequencer #(.MULDIV_LATENCY(1), .CNT_WIDTH(4)) dut1 (
    .clk(clk), .reset(reset), .ID_EX_MemRead(mr), .ID_EX_RegisterRt(exrt),
    .IF_ID_RegisterRs(rs), .IF_ID_RegisterRt(rt), .in_BranchControl(br),
    .IF_ID_MulDiv(md), .clear_counters(clr), .PCWrite(pcw1), .IF_ID_Write(ifw1),
    .ID_EX_Write(idw1), .ID_EX_Bubble(idb1), .EX_MEM_Bubble(exb1),
    .IF_ID_Flush(fl1), .busy(busy1), .stall_count(st1), .flush_count(fc1));

  typedef struct {
    logic       mr;
    logic [4:0] exrt, rs, rt;
    logic       br, clr;
    logic       pcw, ifw, idw, idb, fl;
    logic [3:0] st, fc;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    mr = 1'b0; exrt = 5'd0; rs = 5'd0; rt = 5'd0;
    br = 1'b0; md = 1'b0; clr = 1'b0;
  endtask

  task automatic chk_muldiv_busy(input string tag);
    chk({tag, "_busy"}, busy0, 1'b1);
    chk({tag, "_exb"}, exb0, 1'b1);
    chk({tag, "_pcw"}, pcw0, 1'b0);
    chk({tag, "_ifw"}, ifw0, 1'b0);
    chk({tag, "_idw"}, idw0, 1'b0);
    chk({tag, "_idb"}, idb0, 1'b0);
    chk({tag, "_flush"}, fl0, 1'b0);
    chk({tag, "_lat1_busy"}, busy1, 1'b0);
  endtask

  initial begin
    //            mr exrt  rs    rt    br clr  pcw ifw idw idb fl  st fc
    vecs[0] = '{1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd1, 4'd0};
    vecs[1] = '{1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd1, 4'd0};
    vecs[2] = '{1'b1, 5'd7, 5'd3, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd2, 4'd0};
    vecs[3] = '{1'b0, 5'd7, 5'd7, 5'd7, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd2, 4'd0};
    vecs[4] = '{1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 4'd2, 4'd1};
    vecs[5] = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 4'd2, 4'd2};
    vecs[6] = '{1'b1, 5'd6, 5'd5, 5'd4, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd2, 4'd2};
    vecs[7] = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0};
    vecs[8] = '{1'b1, 5'd9, 5'd9, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 4'd0};
    vecs[9] = '{1'b1, 5'd9, 5'd9, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd1, 4'd0};

    // Reset held with hazardous inputs present
    idle_inputs();
    reset = 1'b1;
    mr = 1'b1; exrt = 5'd5; rs = 5'd5; br = 1'b1; md = 1'b1;
    repeat (3) next_cycle();
    chk("rst_pcw", pcw0, 1'b0);
    chk("rst_ifw", ifw0, 1'b0);
    chk("rst_idw", idw0, 1'b0);
    chk("rst_idb", idb0, 1'b0);
    chk("rst_flush", fl0, 1'b0);
    chk("rst_busy", busy0, 1'b0);
    chk("rst_stall", st0, 4'd0);
    chk("rst_fcnt", fc0, 4'd0);

    reset = 1'b0;
    idle_inputs();
    #1;
    chk("rel_pcw", pcw0, 1'b1);
    chk("rel_ifw", ifw0, 1'b1);
    chk("rel_idw", idw0, 1'b1);
    next_cycle();
    chk("rel_stall", st0, 4'd0);
    chk("rel_fcnt", fc0, 4'd0);

    // RUN-state table
    for (int i = 0; i < 10; i++) begin
      mr = vecs[i].mr; exrt = vecs[i].exrt; rs = vecs[i].rs; rt = vecs[i].rt;
      br = vecs[i].br; clr = vecs[i].clr; md = 1'b0;
      #1;
      chk($sformatf("v%0d_pcw", i), pcw0, vecs[i].pcw);
      chk($sformatf("v%0d_ifw", i), ifw0, vecs[i].ifw);
      chk($sformatf("v%0d_idw", i), idw0, vecs[i].idw);
      chk($sformatf("v%0d_idb", i), idb0, vecs[i].idb);
      chk($sformatf("v%0d_exb", i), exb0, 1'b0);
      chk($sformatf("v%0d_flush", i), fl0, vecs[i].fl);
      chk($sformatf("v%0d_busy", i), busy0, 1'b0);
      next_cycle();
      chk($sformatf("v%0d_stall", i), st0, vecs[i].st);
      chk($sformatf("v%0d_fcnt", i), fc0, vecs[i].fc);
    end

    // Single mult/div with hazards injected mid-occupancy
    idle_inputs();
    clr = 1'b1;
    next_cycle();
    clr = 1'b0;
    md = 1'b1;
    #1;
    chk("md_T_pcw", pcw0, 1'b1);
    chk("md_T_busy", busy0, 1'b0);
    chk("md_T_lat1_pcw", pcw1, 1'b1);
    next_cycle();
    md = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      if (k == 2) begin
        br = 1'b1; mr = 1'b1; exrt = 5'd5; rs = 5'd5;
      end
      #1;
      chk_muldiv_busy($sformatf("md_T%0d", k));
      next_cycle();
      idle_inputs();
    end
    #1;
    chk("md_T4_busy", busy0, 1'b0);
    chk("md_T4_pcw", pcw0, 1'b1);
    chk("md_T4_stall", st0, 4'd3);
    chk("md_T4_fcnt", fc0, 4'd0);
    chk("md_lat1_busy_end", busy1, 1'b0);
    next_cycle();

    // Back-to-back mult/div
    md = 1'b1;
    #1;
    chk("b2b_A_busy", busy0, 1'b0);
    next_cycle();
    for (int k = 1; k <= 3; k++) begin
      chk_muldiv_busy($sformatf("b2b_A%0d", k));
      next_cycle();
    end
    chk("b2b_A4_busy", busy0, 1'b0);
    chk("b2b_A4_pcw", pcw0, 1'b1);
    next_cycle();
    md = 1'b0;
    for (int k = 5; k <= 7; k++) begin
      #1;
      chk_muldiv_busy($sformatf("b2b_A%0d", k));
      next_cycle();
    end
    chk("b2b_A8_busy", busy0, 1'b0);
    chk("b2b_A8_stall", st0, 4'd9);

    // Reset asserted mid-MULDIV
    next_cycle();
    md = 1'b1;
    next_cycle();
    md = 1'b0;
    #1;
    chk("mdrst_busy_pre", busy0, 1'b1);
    next_cycle();
    reset = 1'b1;
    #1;
    chk("mdrst_busy", busy0, 1'b0);
    chk("mdrst_exb", exb0, 1'b0);
    chk("mdrst_pcw", pcw0, 1'b0);
    chk("mdrst_ifw", ifw0, 1'b0);
    chk("mdrst_stall", st0, 4'd0);
    repeat (3) next_cycle();
    reset = 1'b0;
    #1;
    chk("mdrst_rel_busy", busy0, 1'b0);
    chk("mdrst_rel_pcw", pcw0, 1'b1);
    next_cycle();
    chk("mdrst_post_busy", busy0, 1'b0);
    chk("mdrst_post_stall", st0, 4'd0);

    // Saturation and clear
    mr = 1'b1; exrt = 5'd5; rs = 5'd5;
    repeat (20) next_cycle();
    chk("sat_stall", st0, 4'd15);
    chk("sat_fcnt", fc0, 4'd0);
    clr = 1'b1;
    next_cycle();
    chk("clr_stall", st0, 4'd0);
    clr = 1'b0;
    next_cycle();
    chk("clr_then_count", st0, 4'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_sequencer.md
# pipeline_hazard_sequencer

Central stall/flush controller for the 5-stage pipeline. It combines load-use hazard detection, taken-branch flushing and multi-cycle multiply/divide occupancy of EX into one set of per-stage write-enable, bubble and flush controls. It also keeps saturating stall and flush performance counters. It sits beside the IF/ID and ID/EX pipeline registers and drives the PC and pipeline-register enables directly.

## Interface
- MULDIV_LATENCY, 4: total EX-stage cycles a mult/div instruction occupies; legal range 1..16.
- CNT_WIDTH, 16: width of each performance counter.

- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- ID_EX_MemRead  in  1  instruction in EX is a load.
- ID_EX_RegisterRt  in  5  load destination register.
- IF_ID_RegisterRs  in  5  source register Rs of the instruction in ID.
- IF_ID_RegisterRt  in  5  source register Rt of the instruction in ID.
- in_BranchControl  in  1  branch in EX resolved taken.
- IF_ID_MulDiv  in  1  instruction in ID is mult/div.
- clear_counters  in  1  synchronous clear of both counters.
- PCWrite  out  1  PC update enable.
- IF_ID_Write  out  1  IF/ID register enable.
- ID_EX_Write  out  1  ID/EX register enable.
- ID_EX_Bubble  out  1  load NOP into ID/EX.
- EX_MEM_Bubble  out  1  load NOP into EX/MEM.
- IF_ID_Flush  out  1  clear IF/ID.
- busy  out  1  FSM is in MULDIV.
- stall_count  out  CNT_WIDTH  cycles with PCWrite=0.
- flush_count  out  CNT_WIDTH  cycles with IF_ID_Flush=1.

## Operation
- States: RUN and MULDIV. Reset state is RUN. The counter remain has width 4 and resets to 0.
- RUN outputs are evaluated in priority order; the first matching condition applies:
  - Flush, when in_BranchControl=1: IF_ID_Flush=1, ID_EX_Bubble=1, all writes enabled.
  - Load-use, when ID_EX_MemRead=1 and ID_EX_RegisterRt!=0 and ID_EX_RegisterRt equals IF_ID_RegisterRs or IF_ID_RegisterRt: PCWrite=0, IF_ID_Write=0, ID_EX_Bubble=1.
  - Otherwise: PCWrite=IF_ID_Write=ID_EX_Write=1; all bubble and flush outputs are 0.
- Transition RUN->MULDIV occurs when all of the following hold:
  - IF_ID_MulDiv=1;
  - neither the flush nor the load-use condition is active;
  - MULDIV_LATENCY>1.
  - On this transition, remain loads MULDIV_LATENCY-1.
- MULDIV outputs: PCWrite=0, IF_ID_Write=0, ID_EX_Write=0, EX_MEM_Bubble=1, busy=1, IF_ID_Flush=0, ID_EX_Bubble=0.
  - remain decrements each cycle.
  - The FSM moves to RUN on the cycle where remain=1.
- In MULDIV, in_BranchControl and the load-use inputs are ignored. No branch can occupy EX while a mult/div does.
- Counters:
  - stall_count increments in each cycle with PCWrite=0.
  - flush_count increments in each cycle with IF_ID_Flush=1.
  - Both saturate at all-ones.
  - clear_counters has priority over increment; the cleared value is visible the next cycle.
- While reset is asserted, every output is 0 and state/remain/counters are held at their reset values.

## Timing
- All RUN-state controls are combinational from the inputs, with zero-cycle latency.
- Mult/div accepted in cycle T (RUN, no hazard):
  - The FSM is in MULDIV for cycles T+1 .. T+MULDIV_LATENCY-1.
  - It is back in RUN at T+MULDIV_LATENCY.
  - MULDIV_LATENCY=1 never leaves RUN.
- Back-to-back mult/div: the second one is in ID when the FSM returns to RUN. It is accepted that cycle, and MULDIV re-enters at the next edge with no RUN gap in stalls beyond that one cycle.
- Counter values update at the clock edge following the counted cycle.
- Reset asserted mid-MULDIV:
  - Outputs go to 0 immediately, without waiting for a clock edge.
  - The FSM is in RUN with remain=0 on the first edge after reset is released.
- Simultaneous branch flush and load-use in RUN: flush wins, stall_count does not increment, flush_count does.

## Test plan
- Reset: hold reset for 3 cycles mid-stream -> all outputs 0. After release with no hazards -> PCWrite=IF_ID_Write=ID_EX_Write=1, counters 0.
- Load-use: MemRead=1, ID_EX_RegisterRt=5, IF_ID_RegisterRs=5 -> PCWrite=0, ID_EX_Bubble=1, stall_count +1. Repeat with ID_EX_RegisterRt=0 -> no stall.
- Branch: in_BranchControl=1 together with a matching load-use -> IF_ID_Flush=1, ID_EX_Bubble=1, PCWrite=1, flush_count=1, stall_count unchanged.
- Mult/div, MULDIV_LATENCY=4: IF_ID_MulDiv=1 at cycle 10 -> busy=1 and EX_MEM_Bubble=1 in cycles 11-13, RUN at 14, stall_count=3. Repeat with MULDIV_LATENCY=1 -> busy never asserts.
- Reset at cycle 12 of the mult/div above -> outputs 0 immediately, busy=0 after release, stall_count=0.
- Saturation/clear with CNT_WIDTH=4: 20 load-use cycles -> stall_count=15. Pulse clear_counters -> 0 on the next cycle.
